// File: rtl/mux4_serializer_pkg.sv
// Shared types and constants for the 4-channel mux serializer.
// MUX4_SER_PARITY_EN adds a trailing even-parity beat after the four data bits.
package mux_ser_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef MUX4_SER_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } state_t;

  // Beat counter to mux select: MSB-first walks the channels downwards (3-cnt).
  function automatic logic [SEL_W-1:0] cnt_to_sel(input logic [SEL_W-1:0] cnt,
                                                  input logic lsb_first);
    return lsb_first ? cnt : ~cnt;
  endfunction

endpackage

// File: rtl/mux4_serializer_mux.sv
// 4:1 mux built from two levels of 2:1 muxes; selects one bit of the held word.
module mux_4x1_2x1
  import mux_ser_pkg::*;
(
  input  logic [NUM_CH-1:0] d,
  input  logic [SEL_W-1:0]  s,
  output logic              y
);

  logic [1:0] stage1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stage1
      assign stage1[gi] = s[0] ? d[2*gi+1] : d[2*gi];
    end
  endgenerate

  assign y = s[1] ? stage1[1] : stage1[0];

endmodule

// File: rtl/mux4_serializer.sv
// Serializes a 4-bit word one bit per accepted beat through a registered 4:1 mux select.
// Define MUX4_SER_PARITY_EN to append an even-parity beat to every word.
module mux4_serializer
  import mux_ser_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] in_data,
  output logic              sel0,
  output logic              sel1,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam logic LSB_FIRST_L = (LSB_FIRST != 0);

  state_t             state_reg;
  logic [NUM_CH-1:0]  hold_reg;
  logic [SEL_W-1:0]   cnt_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               ser_valid_reg;
  logic               ser_last_reg;
  logic               busy_reg;
  logic               idle_rdy_reg;

  logic               accept;
  logic               bit_xfer;
  logic               mux_y;

  // A new word may also be taken on the final beat so words run back-to-back.
  assign in_ready = idle_rdy_reg | (ser_last_reg & ser_ready);
  assign accept   = in_valid & in_ready;
  assign bit_xfer = ser_valid_reg & ser_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= '0;
      cnt_reg       <= '0;
      sel_reg       <= '0;
      ser_valid_reg <= 1'b0;
      ser_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      idle_rdy_reg  <= 1'b0;
    end else if (accept) begin
      state_reg     <= ST_SHIFT;
      hold_reg      <= in_data;
      cnt_reg       <= '0;
      sel_reg       <= cnt_to_sel('0, LSB_FIRST_L);
      ser_valid_reg <= 1'b1;
      ser_last_reg  <= 1'b0;
      busy_reg      <= 1'b1;
      idle_rdy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          idle_rdy_reg <= 1'b1;
        end
        ST_SHIFT: begin
          if (bit_xfer) begin
            cnt_reg <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
`ifdef MUX4_SER_PARITY_EN
              // sel keeps pointing at the last data channel during the parity beat.
              state_reg    <= ST_PARITY;
              ser_last_reg <= 1'b1;
`else
              state_reg     <= ST_IDLE;
              ser_valid_reg <= 1'b0;
              ser_last_reg  <= 1'b0;
              busy_reg      <= 1'b0;
              idle_rdy_reg  <= 1'b1;
`endif
            end else begin
              sel_reg <= cnt_to_sel(cnt_reg + 2'd1, LSB_FIRST_L);
`ifdef MUX4_SER_PARITY_EN
              ser_last_reg <= 1'b0;
`else
              ser_last_reg <= (cnt_reg == 2'd2);
`endif
            end
          end
        end
`ifdef MUX4_SER_PARITY_EN
        ST_PARITY: begin
          if (bit_xfer) begin
            state_reg     <= ST_IDLE;
            ser_valid_reg <= 1'b0;
            ser_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            idle_rdy_reg  <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  mux_4x1_2x1 u_mux (
    .d (hold_reg),
    .s (sel_reg),
    .y (mux_y)
  );

`ifdef MUX4_SER_PARITY_EN
  assign ser_out = (state_reg == ST_PARITY) ? ^hold_reg : mux_y;
`else
  assign ser_out = mux_y;
`endif

  assign sel0      = sel_reg[0];
  assign sel1      = sel_reg[1];
  assign ser_valid = ser_valid_reg;
  assign ser_last  = ser_last_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mux4_serializer.sv
// Directed bench for mux4_serializer: LSB-first and MSB-first instances sharing clk/rst_n.
module tb_mux4_serializer;

`ifdef MUX4_SER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk;
  logic       rst_n;

  logic       a_in_valid, a_in_ready, a_sel0, a_sel1, a_ser_out, a_ser_valid;
  logic       a_ser_ready, a_ser_last, a_busy;
  logic [3:0] a_in_data;

  logic       b_in_valid, b_in_ready, b_sel0, b_sel1, b_ser_out, b_ser_valid;
  logic       b_ser_ready, b_ser_last, b_busy;
  logic [3:0] b_in_data;

  int total;
  int bad;

  mux4_serializer #(.LSB_FIRST(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .sel0(a_sel0), .sel1(a_sel1), .ser_out(a_ser_out),
    .ser_valid(a_ser_valid), .ser_ready(a_ser_ready), .ser_last(a_ser_last),
    .busy(a_busy)
  );

  mux4_serializer #(.LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .sel0(b_sel0), .sel1(b_sel1), .ser_out(b_ser_out),
    .ser_valid(b_ser_valid), .ser_ready(b_ser_ready), .ser_last(b_ser_last),
    .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    logic [8:0] obs;
    #2;
    obs = {a_sel0, a_sel1, a_ser_out, a_ser_valid, a_ser_last, a_busy, a_in_ready,
           b_ser_valid, b_in_ready};
    total++;
    if (obs !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", obs, 9'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=0", a_in_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({a_in_ready, b_in_ready, a_busy} !== 3'b110) begin
      bad++;
      $display("FAIL ready_after_reset got=%b want=110", {a_in_ready, b_in_ready, a_busy});
    end
    $display("reset: in_ready=%b busy=%b", a_in_ready, a_busy);
  endtask

  task automatic test_lsb_first(input logic [3:0] word, input logic [9:0] exp, input bit stall);
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL lsb_idle_ready got=%b want=1", a_in_ready);
    end
    a_in_valid = 1'b1; a_in_data = word; a_ser_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = ~word;
    #1;
    for (int i = 0; i < NB; i++) begin
      if (stall && i == 2) begin
        a_ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          total++;
          if ({a_sel1, a_sel0, a_ser_out, a_ser_valid, a_ser_last, a_in_ready} !==
              {2'd2, exp[2], 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got=%b want=%b", k,
                     {a_sel1, a_sel0, a_ser_out, a_ser_valid, a_ser_last, a_in_ready},
                     {2'd2, exp[2], 1'b1, 1'b0, 1'b0});
          end
        end
        a_ser_ready = 1'b1;
        #1;
      end
      total++;
      if ({a_ser_valid, a_ser_out, a_ser_last, a_busy, a_in_ready} !==
          {1'b1, exp[i], (i == NB-1), 1'b1, (i == NB-1)}) begin
        bad++;
        $display("FAIL lsb_beat%0d got v/o/l/b/r=%b want=%b", i,
                 {a_ser_valid, a_ser_out, a_ser_last, a_busy, a_in_ready},
                 {1'b1, exp[i], (i == NB-1), 1'b1, (i == NB-1)});
      end
      total++;
      if ({a_sel1, a_sel0} !== ((i < 4) ? 2'(i) : 2'd3)) begin
        bad++;
        $display("FAIL lsb_sel%0d got=%0d want=%0d", i, {a_sel1, a_sel0}, (i < 4) ? i : 3);
      end
      $display("lsb word=%h beat=%0d sel=%0d out=%b last=%b", word, i, {a_sel1, a_sel0},
               a_ser_out, a_ser_last);
      @(posedge clk); #1;
    end
    total++;
    if ({a_ser_valid, a_busy, a_ser_last} !== 3'b000) begin
      bad++;
      $display("FAIL lsb_end_idle got=%b want=000", {a_ser_valid, a_busy, a_ser_last});
    end
  endtask

  task automatic test_msb_first;
    logic [9:0] exp;
`ifdef MUX4_SER_PARITY_EN
    exp = 10'b0000011101;
`else
    exp = 10'b0000001101;
`endif
    b_in_valid = 1'b1; b_in_data = 4'b1011; b_ser_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    #1;
    for (int i = 0; i < NB; i++) begin
      total++;
      if ({b_ser_valid, b_ser_out, b_ser_last, b_sel1, b_sel0} !==
          {1'b1, exp[i], (i == NB-1), ((i < 4) ? 2'(3-i) : 2'd0)}) begin
        bad++;
        $display("FAIL msb_beat%0d got v/o/l/sel=%b want=%b", i,
                 {b_ser_valid, b_ser_out, b_ser_last, b_sel1, b_sel0},
                 {1'b1, exp[i], (i == NB-1), ((i < 4) ? 2'(3-i) : 2'd0)});
      end
      $display("msb beat=%0d sel=%0d out=%b last=%b", i, {b_sel1, b_sel0}, b_ser_out, b_ser_last);
      @(posedge clk); #1;
    end
    total++;
    if (b_ser_valid !== 1'b0) begin
      bad++;
      $display("FAIL msb_end_idle got=%b want=0", b_ser_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp;
`ifdef MUX4_SER_PARITY_EN
    exp = 10'b0010101010;
`else
    exp = 10'b0001011010;
`endif
    a_in_valid = 1'b1; a_in_data = 4'hA; a_ser_ready = 1'b1;
    @(posedge clk); #1;
    a_in_data = 4'h5;
    #1;
    for (int i = 0; i < 2*NB; i++) begin
      total++;
      if ({a_ser_valid, a_ser_out, a_in_ready, a_ser_last} !==
          {1'b1, exp[i], ((i % NB) == NB-1), ((i % NB) == NB-1)}) begin
        bad++;
        $display("FAIL b2b_beat%0d got v/o/r/l=%b want=%b", i,
                 {a_ser_valid, a_ser_out, a_in_ready, a_ser_last},
                 {1'b1, exp[i], ((i % NB) == NB-1), ((i % NB) == NB-1)});
      end
      $display("b2b beat=%0d out=%b in_ready=%b last=%b", i, a_ser_out, a_in_ready, a_ser_last);
      @(posedge clk); #1;
      if (i == NB-1) a_in_valid = 1'b0;
      #1;
    end
    total++;
    if ({a_ser_valid, a_busy} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_end_idle got=%b want=00", {a_ser_valid, a_busy});
    end
  endtask

  task automatic test_reset_mid_word;
    a_in_valid = 1'b1; a_in_data = 4'hF; a_ser_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({a_ser_valid, a_ser_out, a_ser_last} !== 3'b110) begin
        bad++;
        $display("FAIL rst_mid_beat%0d got=%b want=110", i, {a_ser_valid, a_ser_out, a_ser_last});
      end
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_sel0, a_sel1, a_ser_out, a_ser_valid, a_ser_last, a_busy, a_in_ready} !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_async got=%b want=0000000",
               {a_sel0, a_sel1, a_ser_out, a_ser_valid, a_ser_last, a_busy, a_in_ready});
    end
    $display("rst_mid: outputs after async reset valid=%b busy=%b", a_ser_valid, a_busy);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_lsb_first(4'h3, 10'b0000000011, 1'b0);
  endtask

`ifdef MUX4_SER_PARITY_EN
  task automatic test_parity;
    test_lsb_first(4'b0111, 10'b0000010111, 1'b0);
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 4'h0; a_ser_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 4'h0; b_ser_ready = 1'b1;
    test_reset;
`ifdef MUX4_SER_PARITY_EN
    test_lsb_first(4'b1011, 10'b0000011011, 1'b0);
`else
    test_lsb_first(4'b1011, 10'b0000001011, 1'b0);
`endif
    test_msb_first;
`ifdef MUX4_SER_PARITY_EN
    test_lsb_first(4'b1011, 10'b0000011011, 1'b1);
`else
    test_lsb_first(4'b1011, 10'b0000001011, 1'b1);
`endif
    test_back_to_back;
    test_reset_mid_word;
`ifdef MUX4_SER_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_serializer.md
MUX4_SERIALIZER -- requirements
Module: mux4_serializer

Interface
REQ-001 Parameter: LSB_FIRST, default 1; 1 = bit order i0..i3 (sel 0,1,2,3); 0 = i3..i0 (sel 3,2,1,0).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  4  parallel word, bit k = mux channel ik.
REQ-007 sel0  output  1  mux select LSB, registered.
REQ-008 sel1  output  1  mux select MSB, registered.
REQ-009 ser_out  output  1  serial data bit.
REQ-010 ser_valid  output  1  ser_out valid.
REQ-011 ser_ready  input  1  downstream accepts bit.
REQ-012 ser_last  output  1  final bit of the current word.
REQ-013 busy  output  1  word in flight (state != IDLE).

Function
REQ-014 Handshake rule, both sides: a transfer occurs only in a cycle where valid && ready are both high at the rising edge.
REQ-015 FSM states: IDLE, SHIFT, plus PARITY when MUX4_SER_PARITY_EN is defined.
REQ-016 IDLE: in_ready=1 and ser_valid=0; on in_valid && in_ready, latch in_data into hold register, cnt=0, go to SHIFT.
REQ-017 Latency: word accepted at edge N; first bit has ser_valid=1 in the cycle following edge N.
REQ-018 SHIFT: ser_valid=1; {sel1,sel0}=cnt when LSB_FIRST=1, else 3-cnt; ser_out=hold[{sel1,sel0}].
REQ-019 Each bit transfer increments cnt, a 2-bit counter that wraps 3->0.
REQ-020 Stall: with ser_ready=0, ser_out, sel, cnt and ser_last are held unchanged.
REQ-021 ser_last=1 only on the final beat: cnt==3 in SHIFT without parity, or in PARITY.
REQ-022 Back-to-back words: in_ready=1 also on the final beat when ser_ready=1.
  - Simultaneous final-bit transfer and new-word accept: reload hold, cnt=0, stay in SHIFT, no bubble cycle.
REQ-023 Final-beat transfer with no new word accepted: go to IDLE.
REQ-024 in_valid while in_ready=0 is ignored; upstream holds the word.
REQ-025 in_data is ignored in any cycle where in_valid=0.
REQ-026 Sustained throughput: one bit per cycle; 4 bits per word, 5 with parity.

Reset
REQ-027 rst_n low forces the following immediately, regardless of clk:
  - FSM to IDLE; cnt=0; hold=0.
  - sel0=sel1=0; ser_valid=0; ser_last=0; ser_out=0; busy=0; in_ready=0.
REQ-028 in_ready rises in the first cycle after rst_n deasserts.
REQ-029 Reset mid-word abandons the word: no ser_last is produced, and the partial word is never resumed.

Configuration
REQ-030 Macro MUX4_SER_PARITY_EN defined: after bit 3, PARITY state emits one extra beat.
  - Beat value ser_out = ^hold (even parity); sel holds its last value; ser_last=1 on this beat.
REQ-031 Macro MUX4_SER_PARITY_EN undefined: the PARITY state and its logic do not exist; 4 beats per word.

Structure
REQ-032 Package mux_ser_pkg holds the state enum, NUM_CH=4, SEL_W=2.
REQ-033 One sub-module: the existing mux_4x1_2x1 is instantiated for the ser_out data path, driven by hold and the registered sel.

Verification
REQ-034 Reset, then in_data=4'b1011 accepted with ser_ready=1 and LSB_FIRST=1 -> ser_out 1,1,0,1 on sel 0..3; ser_last only on the 4th beat.
REQ-035 LSB_FIRST=0, in_data=4'b1011 -> ser_out 1,0,1,1 on sel 3,2,1,0.
REQ-036 ser_ready held low 3 cycles on beat 2 -> ser_out, sel and ser_valid are frozen; sequence completes unchanged.
REQ-037 Words 4'hA then 4'h5 offered back-to-back -> 8 contiguous valid beats 0,1,0,1,1,0,1,0; in_ready high on beat 4.
REQ-038 rst_n pulsed low on beat 2 of 4'hF -> all outputs 0 asynchronously; next word 4'h3 serializes cleanly from sel 0.
REQ-039 MUX4_SER_PARITY_EN defined, in_data=4'b0111 -> 5 beats 1,1,1,0,1; ser_last on beat 5.
